// File: rtl/uart_digest_tx_if.sv
// Digest handoff from the hash core to the UART transmitter.
// The handshake completes on any rising edge where valid and ready are both high.
interface uart_digest_tx_if #(
    parameter int NUM_BYTES = 32
);
    logic [8*NUM_BYTES-1:0] digest_in;
    logic                   digest_valid;
    logic                   digest_ready;

    modport master (
        output digest_in,
        output digest_valid,
        input  digest_ready
    );

    modport slave (
        input  digest_in,
        input  digest_valid,
        output digest_ready
    );
endinterface

// File: rtl/uart_digest_tx.sv
// Sends a latched digest as NUM_BYTES back-to-back 8N1 UART frames, MSB byte first.
//
// state | meaning
// IDLE  | line high, ready for a digest
// START | start bit (line low)
// DATA  | 8 data bits of the current byte, LSB first
// STOP  | stop bit (line high); then the next byte or IDLE
module uart_digest_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NUM_BYTES    = 32
) (
    input  logic             clk,
    input  logic             rst,
    uart_digest_tx_if.slave  dig,
    output logic             uart_tx,
    output logic             busy,
    output logic             done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BYTE_W = $clog2(NUM_BYTES) + 1;
    localparam int DW     = 8 * NUM_BYTES;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [DW-1:0]     shreg;
    logic              ready_q;
    logic [7:0]        cur_byte;
    logic              baud_wrap;

    assign cur_byte         = shreg[DW-1 -: 8];
    assign baud_wrap        = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign dig.digest_ready = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            shreg    <= '0;
            ready_q  <= 1'b1;
            uart_tx  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (dig.digest_valid && ready_q) begin
                        shreg    <= dig.digest_in;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b0;
                        ready_q  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        bit_cnt <= '0;
                        uart_tx <= cur_byte[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == 3'd7) begin
                            uart_tx <= 1'b1;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            uart_tx <= cur_byte[bit_cnt + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        if (byte_cnt == BYTE_W'(NUM_BYTES - 1)) begin
                            done    <= 1'b1;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            // next start bit follows the stop bit with no idle gap
                            byte_cnt <= byte_cnt + 1'b1;
                            shreg    <= shreg << 8;
                            uart_tx  <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_digest_tx.sv
// Self-checking bench for uart_digest_tx: scoreboard of expected bytes versus a bench UART receiver.
module tb_uart_digest_tx;
    localparam int C  = 4;
    localparam int NB = 32;
    localparam int DW = 8 * NB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx, busy, done;

    uart_digest_tx_if #(.NUM_BYTES(NB)) dig();

    uart_digest_tx #(.CLKS_PER_BIT(C), .NUM_BYTES(NB)) dut (
        .clk     (clk),
        .rst     (rst),
        .dig     (dig),
        .uart_tx (uart_tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    // bench UART receiver, samples mid-bit on the falling edge
    logic       rx_active = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_byte = 8'h00;

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (rst) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (uart_tx === 1'b0) begin
                rx_active = 1'b1;
                rx_t = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == C / 2) chk("start_bit", {31'd0, uart_tx}, 32'd0);
            if ((rx_t % C) == C / 2 && rx_t > C && rx_t < 9 * C) rx_byte[rx_t / C - 1] = uart_tx;
            if (rx_t == 9 * C + C / 2) begin
                chk("stop_bit", {31'd0, uart_tx}, 32'd1);
                if (exp_q.size() == 0) chk("rx_unexpected", {24'd0, rx_byte}, 32'h100);
                else chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
                rx_active = 1'b0;
            end
        end
    end

    task automatic push_bytes(input logic [DW-1:0] d);
        for (int i = NB - 1; i >= 0; i--) exp_q.push_back(d[8*i +: 8]);
    endtask

    task automatic send(input logic [DW-1:0] d);
        @(negedge clk);
        chk("ready_before_hs", {31'd0, dig.digest_ready}, 32'd1);
        dig.digest_in    = d;
        dig.digest_valid = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        push_bytes(d);
        dig.digest_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_lat"}, cyc - hs_cyc, NB * 10 * C);
        chk({tag, "_ready_on_done"}, {31'd0, dig.digest_ready}, 32'd1);
        chk({tag, "_busy_on_done"}, {31'd0, busy}, 32'd0);
    endtask

    function automatic logic [DW-1:0] rand_digest();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d_abc, d_a, d_b, d_c;
        logic [7:0]    b0;
        logic [9:0]    frame;
        int            dc;

        d_abc = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
        dig.digest_in    = '0;
        dig.digest_valid = 1'b0;

        // reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_tx", {31'd0, uart_tx}, 32'd1);
            chk("idle_ready", {31'd0, dig.digest_ready}, 32'd1);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
        end

        // single digest plus bit-level framing of the first byte
        dc = done_cnt;
        b0 = d_abc[DW-1 -: 8];
        frame = {1'b1, b0, 1'b0};
        send(d_abc);
        for (int i = 0; i < 10 * C; i++) begin
            @(negedge clk);
            chk("frame_bit", {31'd0, uart_tx}, {31'd0, frame[i / C]});
            chk("frame_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        chk("next_start", {31'd0, uart_tx}, 32'd0);
        wait_done("abc");
        @(negedge clk);
        chk("done_width", {31'd0, done}, 32'd0);
        chk("abc_done_cnt", done_cnt - dc, 1);
        chk("abc_q_empty", exp_q.size(), 0);

        // valid while busy must be ignored
        dc = done_cnt;
        send({DW{1'b1}});
        repeat (200) @(negedge clk);
        dig.digest_in    = '0;
        dig.digest_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy_ready", {31'd0, dig.digest_ready}, 32'd0);
        end
        dig.digest_valid = 1'b0;
        wait_done("ff");
        repeat (50) @(negedge clk);
        chk("ff_done_cnt", done_cnt - dc, 1);
        chk("ff_q_empty", exp_q.size(), 0);

        // back-to-back with valid held high
        dc = done_cnt;
        d_a = rand_digest();
        d_b = rand_digest();
        @(negedge clk);
        dig.digest_in    = d_a;
        dig.digest_valid = 1'b1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        push_bytes(d_a);
        dig.digest_in = d_b;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        chk("b2b_a_done", {31'd0, done}, 32'd1);
        chk("b2b_a_lat", cyc - hs_cyc, NB * 10 * C);
        chk("b2b_ready", {31'd0, dig.digest_ready}, 32'd1);
        chk("b2b_gap_high", {31'd0, uart_tx}, 32'd1);
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        push_bytes(d_b);
        dig.digest_valid = 1'b0;
        @(negedge clk);
        chk("b2b_start", {31'd0, uart_tx}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done("b2b_b");
        repeat (10) @(negedge clk);
        chk("b2b_done_cnt", done_cnt - dc, 2);
        chk("b2b_q_empty", exp_q.size(), 0);

        // reset mid-frame
        dc = done_cnt;
        d_c = rand_digest();
        send(d_c);
        repeat (500) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst_ready", {31'd0, dig.digest_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 1400; i++) begin
            @(negedge clk);
            chk("rst_line_idle", {31'd0, uart_tx}, 32'd1);
        end
        chk("rst_no_done", done_cnt - dc, 0);
        d_c = rand_digest();
        send(d_c);
        wait_done("post_rst");
        repeat (10) @(negedge clk);
        chk("post_rst_done_cnt", done_cnt - dc, 1);
        chk("post_rst_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_digest_tx.md
Name: uart_digest_tx

Overview:
- Serialises a 256-bit SHA-256 digest onto the UART TX line as 32 raw bytes, 8N1 framing.
- Sits between the hash core's digest output and the `uart_tx` pin of the top level.
- Is the transmit-side counterpart of the UART receive path that loads message bytes into the hash core.
- Accepts one digest per valid/ready handshake and frames it without gaps.

Parameters:
- CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200). Legal range >= 2.
- NUM_BYTES, default 32: bytes per transfer. Input width is 8*NUM_BYTES.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- digest_in  input  8*NUM_BYTES  digest word; sampled only on the handshake cycle.
- digest_valid  input  1  digest_in is valid.
- digest_ready  output  1  block can accept a digest.
- uart_tx  output  1  serial line; idle high.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse after the final stop bit completes.

Behaviour:
- Clocking and reset (already decided): one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: uart_tx=1, digest_ready=1, busy=0, done=0. Bit counter, byte counter and baud counter all = 0. FSM = IDLE.
- Reset asserted mid-frame aborts the transfer. All outputs take their reset values at that clock edge, and no done pulse is generated.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - digest_ready=1 and uart_tx=1.
  - On digest_valid && digest_ready, latch digest_in into the shift register and clear the byte counter.
  - Next state is START. digest_ready=0 and busy=1 from the next cycle.
- START: uart_tx=0 for exactly CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - 8 bits, each held CLKS_PER_BIT cycles, LSB of the current byte first.
  - After bit 7, go to STOP.
- STOP:
  - uart_tx=1 for CLKS_PER_BIT cycles.
  - If bytes remain, increment the byte counter and go directly to START, with no inter-byte idle.
  - After the last byte, go to IDLE and assert done=1 and digest_ready=1 in that same cycle. busy=0 from that cycle.
- Byte order: digest_in[8*NUM_BYTES-1 -: 8] is sent first (big-endian, the standard SHA-256 digest order). Implementation shifts the latched register left by 8 per byte.
- Timing:
  - The start bit of byte 0 appears on uart_tx the first cycle after the handshake cycle.
  - Total busy duration is exactly NUM_BYTES*10*CLKS_PER_BIT cycles.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps. A bit transition occurs on the wrap.
  - No fractional accumulation.
- Bit counter is 3 bits. Byte counter width is $clog2(NUM_BYTES)+1. The last-byte compare is against NUM_BYTES-1.
- digest_valid asserted while busy is ignored. It is not queued and does not disturb the latched data.
- Changes to digest_in after the handshake have no effect on the transfer.
- digest_valid held high through done starts a new transfer:
  - The handshake occurs on the done cycle, since ready=1 there.
  - The next start bit follows one cycle later.
  - Line stays high for exactly 1 cycle between frames.
- uart_tx is driven from a register (glitch-free). No combinational path from inputs to uart_tx.

Test Plan:
1. Reset and idle, CLKS_PER_BIT=4: hold rst 3 cycles, then release. Expect uart_tx=1, digest_ready=1, busy=0, done=0 on every cycle for 50 cycles.
2. Single digest: send SHA-256("abc") = ba7816bf...f20015ad with a one-cycle valid.
   - Start bit appears 1 cycle after the handshake.
   - A bench UART receiver decodes 32 bytes in order 0xBA, 0x78, 0x16 ... 0xAD.
   - done pulses once, exactly 1280 cycles after the handshake.
3. Bit-level framing for first byte 0xBA (CLKS_PER_BIT=4): expect line sequence 0,0,1,0,1,1,1,0,1,1, each level held 4 cycles. Stop bit is followed immediately by the next start bit.
4. Busy rejection: assert digest_valid with all-zero data at cycle 200 of a transfer of 0xFF..FF.
   - digest_ready stays 0.
   - Received bytes are all 0xFF.
   - done pulses only once.
5. Back-to-back: hold digest_valid=1 with digest A, then B. Expect B accepted on A's done cycle, exactly 1 idle-high cycle between frames, and 64 correct bytes.
6. Reset mid-frame: assert rst at cycle 500 of a transfer.
   - Next edge gives uart_tx=1, digest_ready=1, busy=0, and no done pulse.
   - A fresh digest afterwards transmits correctly.
